// File: rtl/c17_resp_analyzer.sv
// Output-response analyzer for the C17 benchmark: folds each 2-bit response
// into a Galois MISR and compares the final signature against a golden value.
module c17_resp_analyzer #(
    parameter int              NOUT  = 2,
    parameter int              SIG_W = 16,
    parameter int              N_VEC = 5,
    parameter logic [SIG_W-1:0] POLY = 16'h1021,
    parameter logic [SIG_W-1:0] SEED = 16'h0000,
    localparam int             CW    = $clog2(N_VEC + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             resp_valid,
    input  logic [NOUT-1:0]  resp,
    input  logic [SIG_W-1:0] exp_sig,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [CW-1:0]    vec_count,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(N_VEC - 1);

    state_t           state;
    state_t           next_state;
    logic [SIG_W-1:0] folded;
    logic             fold_en;
    logic             last_fold;
    logic             load;

    // Shift out the MSB, feed it back through POLY, then inject the response.
    always_comb begin
        folded = {signature[SIG_W-2:0], 1'b0}
               ^ (signature[SIG_W-1] ? POLY : '0)
               ^ SIG_W'(resp);
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        fold_en    = 1'b0;
        last_fold  = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                fold_en = resp_valid;
                if (resp_valid && (vec_count == LAST)) begin
                    last_fold  = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Signature, count and verdict stay frozen outside RUN until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signature <= '0;
            vec_count <= '0;
            pass      <= 1'b0;
        end else if (load) begin
            signature <= SEED;
            vec_count <= '0;
            pass      <= 1'b0;
        end else if (fold_en) begin
            signature <= folded;
            vec_count <= vec_count + CW'(1);
            if (last_fold) begin
                pass <= (folded == exp_sig);
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_c17_resp_analyzer.sv
// Self-checking bench for c17_resp_analyzer: three instances cover the
// default configuration, a 4-vector run and a 1-vector feedback case.
module tb_c17_resp_analyzer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        resp_valid;
    logic [1:0]  resp;
    logic [15:0] exp_sig;

    logic        busy0, done0, pass0;
    logic [15:0] sig0;
    logic [2:0]  cnt0;
    logic [1:0]  st0;
    logic        busy4, done4, pass4;
    logic [15:0] sig4;
    logic [2:0]  cnt4;
    logic [1:0]  st4;
    logic        busy1, done1, pass1;
    logic [15:0] sig1;
    logic [0:0]  cnt1;
    logic [1:0]  st1;

    int          n_vec;
    int          n_err;
    logic [15:0] exp_q[$];
    logic [1:0]  vecs[0:4];

    c17_resp_analyzer u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid),
        .resp(resp), .exp_sig(exp_sig), .busy(busy0), .done(done0),
        .pass(pass0), .signature(sig0), .vec_count(cnt0), .state_dbg(st0)
    );

    c17_resp_analyzer #(.N_VEC(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid),
        .resp(resp), .exp_sig(exp_sig), .busy(busy4), .done(done4),
        .pass(pass4), .signature(sig4), .vec_count(cnt4), .state_dbg(st4)
    );

    c17_resp_analyzer #(.N_VEC(1), .SEED(16'h8000)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid),
        .resp(resp), .exp_sig(exp_sig), .busy(busy1), .done(done1),
        .pass(pass1), .signature(sig1), .vec_count(cnt1), .state_dbg(st1)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] fold(input logic [15:0] s, input logic [1:0] r);
        fold = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, r};
    endfunction

    task automatic apply_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        resp_valid = 1'b0;
        resp       = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One run on the default instance. Caller may request gapped valids, a
    // stray start mid-run, a pre-loaded run, or a chained start in DONE.
    task automatic run_dut0(input logic [15:0] golden, input bit gapped,
                            input bit poke_start, input bit preloaded,
                            input bit chain_next);
        logic [15:0] m;
        logic [15:0] got;
        int folded;
        int cyc;
        bit fired;
        exp_sig = golden;
        if (!preloaded) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n_vec++;
            if (busy0 !== 1'b1 || sig0 !== 16'h0000 || cnt0 !== 3'd0) begin
                n_err++;
                $display("FAIL load: busy=%b sig=%h cnt=%0d want busy=1 sig=0000 cnt=0", busy0, sig0, cnt0);
            end
        end
        m = 16'h0000;
        folded = 0;
        cyc = 0;
        while (folded < 5 && cyc < 100) begin
            fired = !(gapped && (cyc % 3 != 0));
            resp_valid = fired;
            start = (poke_start && cyc == 2);
            if (fired) begin
                resp = vecs[folded];
                m = fold(m, vecs[folded]);
                exp_q.push_back(m);
                folded++;
            end else begin
                resp = 2'($urandom_range(0, 3));
            end
            @(posedge clk); #1;
            cyc++;
            if (fired) begin
                got = exp_q.pop_front();
                n_vec++;
                if (sig0 !== got) begin
                    n_err++;
                    $display("FAIL fold_sig: sig=%h want %h", sig0, got);
                end
            end
            n_vec++;
            if (cnt0 !== 3'(folded)) begin
                n_err++;
                $display("FAIL fold_count: cnt=%0d want %0d", cnt0, folded);
            end
            n_vec++;
            if (done0 !== (folded == 5)) begin
                n_err++;
                $display("FAIL done_timing: done=%b want %b", done0, folded == 5);
            end
        end
        resp_valid = 1'b0;
        start = 1'b0;
        n_vec++;
        if (folded != 5 || busy0 !== 1'b0 || pass0 !== (m == golden)) begin
            n_err++;
            $display("FAIL final: folded=%0d busy=%b pass=%b want 5 0 %b", folded, busy0, pass0, m == golden);
        end
        if (chain_next) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n_vec++;
            if (busy0 !== 1'b1 || done0 !== 1'b0 || pass0 !== 1'b0 || sig0 !== 16'h0000 || cnt0 !== 3'd0) begin
                n_err++;
                $display("FAIL chain_load: busy=%b done=%b pass=%b sig=%h cnt=%0d want 1 0 0 0000 0",
                         busy0, done0, pass0, sig0, cnt0);
            end
        end else begin
            resp_valid = 1'b1;
            resp = 2'b11;
            @(posedge clk); #1;
            resp_valid = 1'b0;
            n_vec++;
            if (done0 !== 1'b0 || sig0 !== m || cnt0 !== 3'd5 || pass0 !== (m == golden)) begin
                n_err++;
                $display("FAIL hold: done=%b sig=%h cnt=%0d pass=%b want 0 %h 5 %b",
                         done0, sig0, cnt0, pass0, m, m == golden);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start = 1'b0;
        resp_valid = 1'b0;
        resp = 2'b00;
        exp_sig = 16'h0000;
        #3 rst_n = 1'b0;
        #1;
        n_vec++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || pass0 !== 1'b0 || sig0 !== 16'h0 || cnt0 !== 3'd0) begin
            n_err++;
            $display("FAIL reset_init: busy=%b done=%b pass=%b sig=%h cnt=%0d want all 0",
                     busy0, done0, pass0, sig0, cnt0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            resp_valid = 1'b1;
            resp = 2'($urandom_range(1, 3));
            @(posedge clk); #1;
        end
        resp_valid = 1'b0;
        n_vec++;
        if (cnt0 !== 3'd3 || busy0 !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: cnt=%0d busy=%b want 3 1", cnt0, busy0);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || pass0 !== 1'b0 || sig0 !== 16'h0 || cnt0 !== 3'd0) begin
            n_err++;
            $display("FAIL reset_midrun: busy=%b done=%b pass=%b sig=%h cnt=%0d want all 0",
                     busy0, done0, pass0, sig0, cnt0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            resp_valid = 1'b1;
            resp = 2'($urandom_range(1, 3));
            @(posedge clk); #1;
            n_vec++;
            if (sig0 !== 16'h0 || cnt0 !== 3'd0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
                n_err++;
                $display("FAIL idle_valid: sig=%h cnt=%0d busy=%b done=%b want 0 0 0 0",
                         sig0, cnt0, busy0, done0);
            end
        end
        resp_valid = 1'b0;
    endtask

    task automatic test_all_zero();
        apply_reset();
        for (int i = 0; i < 5; i++) vecs[i] = 2'b00;
        run_dut0(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_shift_pattern(input logic [15:0] golden);
        logic [1:0]  seq[0:3];
        logic [15:0] want[0:3];
        logic [15:0] got;
        apply_reset();
        seq[0] = 2'b01; seq[1] = 2'b00; seq[2] = 2'b00; seq[3] = 2'b00;
        want[0] = 16'h0001; want[1] = 16'h0002; want[2] = 16'h0004; want[3] = 16'h0008;
        exp_sig = golden;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            resp_valid = 1'b1;
            resp = seq[i];
            exp_q.push_back(want[i]);
            @(posedge clk); #1;
            got = exp_q.pop_front();
            n_vec++;
            if (sig4 !== got || cnt4 !== 3'(i + 1)) begin
                n_err++;
                $display("FAIL shift_sig: step=%0d sig=%h cnt=%0d want %h %0d", i, sig4, cnt4, got, i + 1);
            end
        end
        resp_valid = 1'b0;
        n_vec++;
        if (done4 !== 1'b1 || pass4 !== (golden == 16'h0008)) begin
            n_err++;
            $display("FAIL shift_pass: done=%b pass=%b want 1 %b", done4, pass4, golden == 16'h0008);
        end
    endtask

    task automatic test_feedback();
        apply_reset();
        exp_sig = 16'h1021;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_vec++;
        if (sig1 !== 16'h8000 || busy1 !== 1'b1) begin
            n_err++;
            $display("FAIL fb_seed: sig=%h busy=%b want 8000 1", sig1, busy1);
        end
        resp_valid = 1'b1;
        resp = 2'b00;
        @(posedge clk); #1;
        resp_valid = 1'b0;
        n_vec++;
        if (sig1 !== 16'h1021 || cnt1 !== 1'b1 || done1 !== 1'b1 || pass1 !== 1'b1) begin
            n_err++;
            $display("FAIL feedback: sig=%h cnt=%0d done=%b pass=%b want 1021 1 1 1", sig1, cnt1, done1, pass1);
        end
    endtask

    task automatic test_gapped();
        logic [15:0] m;
        apply_reset();
        for (int i = 0; i < 5; i++) vecs[i] = 2'($urandom_range(0, 3));
        m = 16'h0000;
        for (int i = 0; i < 5; i++) m = fold(m, vecs[i]);
        run_dut0(m, 1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (sig0 !== m) begin
            n_err++;
            $display("FAIL b2b_ref: sig=%h want %h", sig0, m);
        end
        run_dut0(m, 1'b1, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (sig0 !== m || pass0 !== 1'b1) begin
            n_err++;
            $display("FAIL gapped_sig: sig=%h pass=%b want %h 1", sig0, pass0, m);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] m;
        apply_reset();
        for (int i = 0; i < 5; i++) vecs[i] = 2'($urandom_range(0, 3));
        m = 16'h0000;
        for (int i = 0; i < 5; i++) m = fold(m, vecs[i]);
        run_dut0(m, 1'b0, 1'b0, 1'b0, 1'b1);
        run_dut0(m ^ 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_all_zero();
        test_shift_pattern(16'h0008);
        test_shift_pattern(16'h0009);
        test_feedback();
        test_gapped();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
